// File: rtl/uart_tx_feeder_if.sv
// Handshake bundle between a byte producer/transmitter (master) and uart_tx_feeder (slave).
// The ovf/ovf_clr pair exists only when UART_TX_FEEDER_OVF_EN is defined.
interface uart_tx_feeder_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          tx_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          busy;
`ifdef UART_TX_FEEDER_OVF_EN
  logic          ovf;
  logic          ovf_clr;

  modport master (
    output wr_en, wr_data, tx_ready, ovf_clr,
    input  full, empty, level, tx_start, tx_data, busy, ovf
  );

  modport slave (
    input  wr_en, wr_data, tx_ready, ovf_clr,
    output full, empty, level, tx_start, tx_data, busy, ovf
  );
`else
  modport master (
    output wr_en, wr_data, tx_ready,
    input  full, empty, level, tx_start, tx_data, busy
  );

  modport slave (
    input  wr_en, wr_data, tx_ready,
    output full, empty, level, tx_start, tx_data, busy
  );
`endif
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter through a start/ready handshake (IDLE/START/DRAIN).
// Optional sticky overflow flag enabled by defining UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          tx_clk,
  input  logic          reset,
  uart_tx_feeder_if.slave bus
);

  localparam logic [AW:0] DEPTH_LV = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic [AW:0]   level_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          busy_r;
  logic          tx_start_r;
  logic [7:0]    tx_data_r;
  logic          wr_acc_s;
  logic          drop_s;
  logic          pop_s;

  // Write acceptance uses the pre-edge full flag, so a same-cycle pop never rescues a write.
  always_comb begin
    wr_acc_s    = bus.wr_en & ~full_r;
    drop_s      = bus.wr_en & full_r;
    pop_s       = (state_r == IDLE) & ~empty_r & bus.tx_ready;
    level_nxt_s = level_r;
    if (wr_acc_s && !pop_s) begin
      level_nxt_s = level_r + (AW+1)'(1);
    end else if (!wr_acc_s && pop_s) begin
      level_nxt_s = level_r - (AW+1)'(1);
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge tx_clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= bus.wr_data;
    end
  end

  // Pointers, level and the registered full/empty flags.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == DEPTH_LV);
      empty_r <= (level_nxt_s == '0);
    end
  end

  // Transmit handshake FSM with registered start/data/busy.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            tx_data_r  <= mem_r[rd_ptr_r];
            tx_start_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= START;
          end
        end
        START: begin
          if (!bus.tx_ready) begin
            tx_start_r <= 1'b0;
            state_r    <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.tx_ready) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          tx_start_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  logic ovf_r;

  // Sticky overflow: a drop outranks a simultaneous clear.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  assign bus.ovf = ovf_r;
`endif

  assign bus.full     = full_r;
  assign bus.empty    = empty_r;
  assign bus.level    = level_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.busy     = busy_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized self-checking bench for uart_tx_feeder against a queue-based handshake model.
// Covers the UART_TX_FEEDER_OVF_EN build when the macro is defined.
module tb_uart_tx_feeder;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic tx_clk;
  logic reset;

  uart_tx_feeder_if #(.AW(AW)) bus ();

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .tx_clk (tx_clk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: byte queue plus transmitter-side phase (0 waiting, 1 started, 2 draining)
  logic [7:0] mq[$];
  logic [7:0] delivered[$];
  logic [7:0] rcv[$];
  int         phase = 0;
  logic       m_start = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ovf   = 1'b0;
  logic       prev_start = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("level",    32'(bus.level),    32'(mq.size()));
    check_val("full",     32'(bus.full),     32'(mq.size() == DEPTH));
    check_val("empty",    32'(bus.empty),    32'(mq.size() == 0));
    check_val("tx_start", 32'(bus.tx_start), 32'(m_start));
    check_val("tx_data",  32'(bus.tx_data),  32'(m_data));
    check_val("busy",     32'(bus.busy),     32'(phase != 0));
`ifdef UART_TX_FEEDER_OVF_EN
    check_val("ovf",      32'(bus.ovf),      32'(m_ovf));
`endif
  endtask

  task automatic cycle(input logic we, input logic [7:0] wd, input logic rdy, input logic clr);
    logic acc;
    logic pop;
    @(negedge tx_clk);
    bus.wr_en    = we;
    bus.wr_data  = wd;
    bus.tx_ready = rdy;
`ifdef UART_TX_FEEDER_OVF_EN
    bus.ovf_clr  = clr;
`endif
    @(posedge tx_clk);
    acc = we && (mq.size() < DEPTH);
    pop = (phase == 0) && (mq.size() > 0) && rdy;
    if (pop) begin
      m_data  = mq.pop_front();
      m_start = 1'b1;
      phase   = 1;
      delivered.push_back(m_data);
    end else if (phase == 1 && !rdy) begin
      m_start = 1'b0;
      phase   = 2;
    end else if (phase == 2 && rdy) begin
      phase   = 0;
    end
    if (acc) mq.push_back(wd);
    if (we && !acc) m_ovf = 1'b1;
    else if (clr)   m_ovf = 1'b0;
    #1;
    check_outputs();
    if (bus.tx_start && !prev_start) rcv.push_back(bus.tx_data);
    prev_start = bus.tx_start;
  endtask

  task automatic compare_stream(input string tag);
    check_val({tag, "_count"}, 32'(rcv.size()), 32'(delivered.size()));
    for (int i = 0; i < rcv.size() && i < delivered.size(); i++) begin
      check_val({tag, "_byte"}, 32'(rcv[i]), 32'(delivered[i]));
    end
    rcv.delete();
    delivered.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || phase != 0) && n < 300) begin
      cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    check_val("drain_timeout", 32'(n >= 300), 32'(0));
  endtask

  task automatic do_reset();
    compare_stream("pre_rst");
    #2;
    reset = 1'b1;
    #1;
    check_val("rst_tx_start", 32'(bus.tx_start), 32'(0));
    check_val("rst_tx_data",  32'(bus.tx_data),  32'(8'h00));
    check_val("rst_busy",     32'(bus.busy),     32'(0));
    check_val("rst_empty",    32'(bus.empty),    32'(1));
    check_val("rst_full",     32'(bus.full),     32'(0));
    check_val("rst_level",    32'(bus.level),    32'(0));
`ifdef UART_TX_FEEDER_OVF_EN
    check_val("rst_ovf",      32'(bus.ovf),      32'(0));
`endif
    mq.delete();
    phase      = 0;
    m_start    = 1'b0;
    m_data     = 8'h00;
    m_ovf      = 1'b0;
    prev_start = 1'b0;
    @(negedge tx_clk);
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    bus.tx_ready = 1'b1;
`ifdef UART_TX_FEEDER_OVF_EN
    bus.ovf_clr  = 1'b0;
`endif
    reset = 1'b0;
  endtask

  initial begin
    int sent;
    int guard;
    logic we;
    reset        = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    bus.tx_ready = 1'b1;
`ifdef UART_TX_FEEDER_OVF_EN
    bus.ovf_clr  = 1'b0;
`endif
    repeat (3) @(posedge tx_clk);
    do_reset();

    // Single byte A5 with a well-behaved transmitter
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    check_val("a5_no_fallthrough", 32'(bus.tx_start), 32'(0));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("a5_start", 32'(bus.tx_start), 32'(1));
    check_val("a5_data",  32'(bus.tx_data),  32'(8'hA5));
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("a5_hold", 32'(bus.tx_start), 32'(1));
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check_val("a5_drop", 32'(bus.tx_start), 32'(0));
    check_val("a5_busy_drain", 32'(bus.busy), 32'(1));
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("a5_busy_low", 32'(bus.busy), 32'(0));
    compare_stream("a5");

    // Burst 01..08 while the transmitter is unavailable, then release
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check_val("burst_full",  32'(bus.full),  32'(1));
    check_val("burst_level", 32'(bus.level), 32'(8));
    drain();
    check_val("burst_pulses", 32'(rcv.size()), 32'(8));
    for (int i = 0; i < rcv.size(); i++) check_val("burst_order", 32'(rcv[i]), 32'(i + 1));
    compare_stream("burst");

    // Overflow: nine writes with tx_ready low
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    check_val("ovf_level", 32'(bus.level), 32'(8));
`ifdef UART_TX_FEEDER_OVF_EN
    check_val("ovf_set", 32'(bus.ovf), 32'(1));
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    check_val("ovf_drop_wins", 32'(bus.ovf), 32'(1));
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_val("ovf_clr", 32'(bus.ovf), 32'(0));
`endif
    drain();
    compare_stream("ovf");

    // Simultaneous write and pop at level 3, then at level 8
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h53, 1'b1, 1'b0);
    check_val("sim_lvl3", 32'(bus.level), 32'(3));
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check_val("sim_full", 32'(bus.full), 32'(1));
    cycle(1'b1, 8'h99, 1'b1, 1'b0);
    check_val("sim_lvl8_drop", 32'(bus.level), 32'(7));
    drain();
    compare_stream("sim");
`ifdef UART_TX_FEEDER_OVF_EN
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
`endif

    // Reset while in START with four bytes still queued
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("midrst_start", 32'(bus.tx_start), 32'(1));
    check_val("midrst_level", 32'(bus.level),    32'(4));
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check_val("post_rst_nostart", 32'(bus.tx_start), 32'(0));
    compare_stream("post_rst");

    // Pointer wrap: 20 bytes with random wr_en and random transmitter
    sent  = 0;
    guard = 0;
    while (sent < 20 && guard < 400) begin
      we = 1'($urandom_range(0, 1)) && (mq.size() < DEPTH);
      cycle(we, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      if (we) sent++;
      guard++;
    end
    check_val("wrap_timeout", 32'(guard >= 400), 32'(0));
    drain();
    check_val("wrap_count", 32'(rcv.size()), 32'(20));
    compare_stream("wrap");

    // Random soak including overflow pressure
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
    end
    drain();
    compare_stream("soak");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 Parameter: DEPTH, 8, FIFO depth in bytes, power of two, minimum 2.
REQ-002 Parameter: AW, 3, pointer width, equal to log2(DEPTH).
REQ-003 tx_clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  write strobe; one byte per cycle when high.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 full  output  1  high when level == DEPTH.
REQ-008 empty  output  1  high when level == 0.
REQ-009 level  output  AW+1  number of bytes held, 0..DEPTH.
REQ-010 tx_ready  input  1  transmitter availability; high means idle.
REQ-011 tx_start  output  1  start request to the transmitter, registered.
REQ-012 tx_data  output  8  byte presented to the transmitter, registered, stable while tx_start is high.
REQ-013 busy  output  1  high when FSM is not IDLE.

Function
REQ-014 The FIFO shall be a circular buffer with AW-bit read and write pointers that wrap from DEPTH-1 to 0.
REQ-015 A write shall be accepted when wr_en=1 and level<DEPTH at the clock edge; a write while full shall be dropped, and a same-cycle pop shall not rescue it.
REQ-016 No fall-through: a byte written at edge k shall be poppable no earlier than edge k+1.
REQ-017 A same-cycle accepted write and pop shall leave level unchanged.
REQ-018 The FSM shall have three states: IDLE, START, DRAIN.
REQ-019 IDLE: when empty=0 and tx_ready=1, pop the head byte into tx_data, set tx_start=1, go to START.
REQ-020 START: hold tx_start=1 and tx_data; when tx_ready=0 is sampled, clear tx_start and go to DRAIN.
REQ-021 DRAIN: hold tx_start=0; when tx_ready=1 is sampled, go to IDLE.
REQ-022 The block shall issue at most one pop per transmitted byte and never pop outside the IDLE->START transition.
REQ-023 If tx_ready is already 0 when the FIFO becomes non-empty, the FSM shall stay in IDLE until tx_ready=1.
REQ-024 Latency: a write into an empty FIFO at edge k, with tx_ready=1, shall produce tx_start=1 after edge k+1.
REQ-025 Byte order at tx_data shall equal write order; no byte may be duplicated or skipped.
REQ-026 tx_start shall never be high while the FSM is in DRAIN or IDLE.

Reset
REQ-027 On reset=1, the block shall asynchronously clear both pointers and level, and go to IDLE, with tx_start=0, tx_data=8'h00, busy=0, empty=1, full=0.
REQ-028 Reset mid-transfer shall discard all queued bytes and drop tx_start on the same assertion, with no pending pop retained.
REQ-029 FIFO storage contents need not be reset.

Configuration
REQ-030 Macro UART_TX_FEEDER_OVF_EN: when defined, add output ovf (1 bit) and input ovf_clr (1 bit).
REQ-031 With UART_TX_FEEDER_OVF_EN defined, ovf shall be set by any dropped write and cleared by ovf_clr=1; a drop in the same cycle as ovf_clr shall win, leaving ovf=1. Reset shall clear ovf to 0.
REQ-032 Without UART_TX_FEEDER_OVF_EN, these ports and their logic shall be absent, and all other behaviour shall be identical.

Verification
REQ-033 Reset, tx_ready=1, write 8'hA5 -> tx_start high one edge later with tx_data=A5; tx_start drops the cycle after tx_ready falls; busy low after tx_ready returns.
REQ-034 Burst-write 8'h01..8'h08 with DEPTH=8 -> full=1, level=8; the transmitter model receives 01..08 in order with exactly one start pulse each.
REQ-035 Write 9 bytes back-to-back with tx_ready held 0 -> 9th byte dropped, level=8, ovf=1 (macro on); ovf_clr pulse -> ovf=0.
REQ-036 Simultaneous write and pop at level=3 -> level stays 3; at level=8 the write is dropped despite the pop.
REQ-037 Assert reset while in START with 4 bytes queued -> tx_start=0, empty=1, level=0; after release, no start until a new write.
REQ-038 Pointer wrap: 20 bytes streamed through DEPTH=8 with random wr_en -> output sequence matches input exactly.
